// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: multi-channel scan scheduler for the serial ADC block.
// Walks the enabled-channel mask in ascending order, one conversion at a time,
// paces scan rounds with a programmable period timer and keeps the latest result
// of every channel in a small register file.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   scan_en             level enable for scanning
//   ch_mask             enabled channels (bit i = channel i), sampled at round start
//   period              round period in clk cycles, sampled while waiting
//   spi_start           one-cycle conversion request to the SPI block
//   spi_channel         channel being converted
//   spi_done, spi_data  conversion complete strobe and result
//   res_valid           one-cycle pulse when a result is stored
//   res_ch, res_data    channel and value of the stored result
//   rd_ch, rd_data      combinational register-file read port
//   busy                high whenever not idle
//   round_done          one-cycle pulse at the end of each scan round
//   timeout_err         sticky skipped-channel flag, cleared by reset or scan_en rise
module adc_scan_ctrl #(
  parameter int unsigned NUM_CH  = 8,
  parameter int unsigned CH_W    = 3,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned PER_W   = 16,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [PER_W-1:0]  period,
  output logic              spi_start,
  output logic [CH_W-1:0]   spi_channel,
  input  logic              spi_done,
  input  logic [DATA_W-1:0] spi_data,
  output logic              res_valid,
  output logic [CH_W-1:0]   res_ch,
  output logic [DATA_W-1:0] res_data,
  input  logic [CH_W-1:0]   rd_ch,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              round_done,
  output logic              timeout_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StFind, StStart, StWaitDone, StWaitTmr} state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  // One extra bit so that a pointer past the last channel means "round over".
  logic [CH_W:0]       ptr_q, ptr_d;
  logic [PER_W-1:0]    tmr_q, tmr_d;
  logic [TO_W-1:0]     wd_q, wd_d;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic                res_valid_q, res_valid_d;
  logic [CH_W-1:0]     res_ch_q, res_ch_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                terr_q, terr_d;
  logic                scan_en_q;
  logic                done_q;
  logic [DATA_W-1:0]   result_q [NUM_CH];

  logic                hit;
  logic [CH_W-1:0]     hit_ch;
  logic [PER_W-1:0]    tmr_inc;
  logic                tmr_ready;
  logic                done_rise;
  logic [CH_W:0]       ptr_next;

  // Lowest enabled channel at or above the pointer.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!hit && mask_q[i] && ((CH_W+1)'(i) >= ptr_q)) begin
        hit    = 1'b1;
        hit_ch = CH_W'(i);
      end
    end
  end

  assign tmr_inc   = (&tmr_q) ? tmr_q : tmr_q + PER_W'(1);
  // period 0 and 1 both mean back-to-back rounds.
  assign tmr_ready = (period <= PER_W'(1)) || (tmr_q >= period - PER_W'(1));
  // Only the first cycle of a held spi_done counts as a completion.
  assign done_rise = spi_done && !done_q;
  assign ptr_next  = {1'b0, chan_q} + (CH_W+1)'(1);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ptr_d       = ptr_q;
    tmr_d       = tmr_q;
    wd_d        = wd_q;
    chan_d      = chan_q;
    res_valid_d = 1'b0;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    terr_d      = terr_q;

    if (scan_en && !scan_en_q) terr_d = 1'b0;
    if (state_q != StIdle) tmr_d = tmr_inc;

    case (state_q)
      StIdle: begin
        if (scan_en && (|ch_mask)) begin
          mask_d  = ch_mask;
          ptr_d   = '0;
          tmr_d   = '0;
          state_d = StFind;
        end
      end
      StFind: begin
        if (!scan_en) begin
          state_d = StIdle;
        end else if (hit) begin
          chan_d  = hit_ch;
          state_d = StStart;
        end else begin
          state_d = StWaitTmr;
        end
      end
      StStart: begin
        // Watchdog counts cycles since the start pulse.
        wd_d    = TO_W'(1);
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done_rise) begin
          res_valid_d = 1'b1;
          res_ch_d    = chan_q;
          res_data_d  = spi_data;
          ptr_d       = ptr_next;
          state_d     = StFind;
        end else if (wd_q >= TO_W'(TIMEOUT)) begin
          terr_d  = 1'b1;
          ptr_d   = ptr_next;
          state_d = StFind;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      StWaitTmr: begin
        if (!scan_en) begin
          state_d = StIdle;
        end else if (tmr_ready) begin
          if (|ch_mask) begin
            mask_d  = ch_mask;
            ptr_d   = '0;
            tmr_d   = '0;
            state_d = StFind;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mask_q      <= '0;
      ptr_q       <= '0;
      tmr_q       <= '0;
      wd_q        <= '0;
      chan_q      <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      terr_q      <= 1'b0;
      scan_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      tmr_q       <= tmr_d;
      wd_q        <= wd_d;
      chan_q      <= chan_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      terr_q      <= terr_d;
      scan_en_q   <= scan_en;
      done_q      <= spi_done;
    end
  end

  // Written from the res_* registers so a same-cycle read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) result_q[i] <= '0;
    end else if (res_valid_q) begin
      result_q[res_ch_q] <= res_data_q;
    end
  end

  assign spi_start   = (state_q == StStart);
  assign spi_channel = chan_q;
  assign res_valid   = res_valid_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign rd_data     = result_q[rd_ch];
  assign busy        = (state_q != StIdle);
  assign round_done  = (state_q == StFind) && !hit;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl: stimulus pushes expected start channels and
// results into queues; monitors pop and compare whenever the DUT presents them.
module tb_adc_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_en = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [15:0] period = '0;
  logic        spi_start;
  logic [2:0]  spi_channel;
  logic        spi_done = 1'b0;
  logic [11:0] spi_data = '0;
  logic        res_valid;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic [2:0]  rd_ch = '0;
  logic [11:0] rd_data;
  logic        busy;
  logic        round_done;
  logic        timeout_err;

  adc_scan_ctrl #(
    .NUM_CH (8),
    .CH_W   (3),
    .DATA_W (12),
    .PER_W  (16),
    .TIMEOUT(1024)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_en    (scan_en),
    .ch_mask    (ch_mask),
    .period     (period),
    .spi_start  (spi_start),
    .spi_channel(spi_channel),
    .spi_done   (spi_done),
    .spi_data   (spi_data),
    .res_valid  (res_valid),
    .res_ch     (res_ch),
    .res_data   (res_data),
    .rd_ch      (rd_ch),
    .rd_data    (rd_data),
    .busy       (busy),
    .round_done (round_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  int          start_q[$];
  logic [31:0] res_q[$];
  int start_cnt = 0;
  int last_start_cyc = 0;
  int rd_cnt = 0;
  int last_rd_cyc = 0;
  int silent_ch = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  // Start / round monitor.
  initial forever begin
    @(posedge clk);
    #1;
    if (spi_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      if (start_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: channel %0d, none required", spi_channel);
      end else begin
        check("start_channel", 32'(spi_channel), 32'(start_q.pop_front()));
      end
    end
    if (round_done) begin
      rd_cnt++;
      last_rd_cyc = cyc;
    end
  end

  // Result monitor.
  initial forever begin
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (res_valid) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: ch %0d data %0h, none required", res_ch, res_data);
      end else begin
        e = res_q.pop_front();
        check("res_ch", 32'(res_ch), e >> 16);
        check("res_data", 32'(res_data), e & 32'hFFFF);
      end
    end
  end

  // SPI responder: done 40 cycles after start, data = 0x100 + channel.
  initial begin : responder
    int ch;
    forever begin
      @(posedge clk);
      #1;
      if (spi_start && rst_n) begin
        ch = int'(spi_channel);
        if (ch != silent_ch) begin
          repeat (40) @(posedge clk);
          #1;
          spi_data = 12'h100 + 12'(ch);
          spi_done = 1'b1;
          @(posedge clk);
          #1;
          spi_done = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int b = budget;
    while (start_cnt < n && b > 0) begin
      cycles(1);
      b--;
    end
    check(name, 32'(start_cnt >= n), 32'd1);
  endtask

  task automatic wait_rounds(input int n, input int budget, input string name);
    int b = budget;
    while (rd_cnt < n && b > 0) begin
      cycles(1);
      b--;
    end
    check(name, 32'(rd_cnt >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int b = budget;
    while (busy && b > 0) begin
      cycles(1);
      b--;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic push_start(input int ch);
    start_q.push_back(ch);
  endtask

  task automatic push_res(input int ch);
    res_q.push_back((32'(ch) << 16) | (32'h100 + 32'(ch)));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_spi_start"}, 32'(spi_start), 32'd0);
    check({tag, "_spi_channel"}, 32'(spi_channel), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_ch"}, 32'(res_ch), 32'd0);
    check({tag, "_res_data"}, 32'(res_data), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_round_done"}, 32'(round_done), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  int base, rb, s, ta, tb_t, rcyc;

  initial begin
    #3;
    check_zero_outputs("reset");
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Timeout: channel 3 silent.
    silent_ch = 3;
    base = start_cnt;
    rb = rd_cnt;
    for (int c = 0; c < 4; c++) push_start(c);
    for (int c = 0; c < 3; c++) push_res(c);
    ch_mask = 8'h0F;
    period = 16'd5000;
    scan_en = 1'b1;
    wait_starts(base + 4, 400, "t3_starts");
    s = last_start_cyc;
    cycles(s + 1020 - cyc);
    check("t3_no_early_timeout", 32'(timeout_err), 32'd0);
    cycles(10);
    check("t3_timeout_err", 32'(timeout_err), 32'd1);
    wait_rounds(rb + 1, 200, "t3_round_done");
    rd_ch = 3'd3;
    #1;
    check("t3_result3", 32'(rd_data), 32'd0);
    rd_ch = 3'd2;
    #1;
    check("t3_result2", 32'(rd_data), 32'h102);
    scan_en = 1'b0;
    silent_ch = -1;
    wait_idle(50, "t3_idle");
    check("t3_timeout_sticky", 32'(timeout_err), 32'd1);

    // Basic scan 0,2,7 and round pacing.
    base = start_cnt;
    rb = rd_cnt;
    push_start(0); push_start(2); push_start(7); push_start(0);
    push_res(0); push_res(2); push_res(7); push_res(0);
    ch_mask = 8'b1000_0101;
    period = 16'd1000;
    scan_en = 1'b1;
    cycles(2);
    check("t1_timeout_cleared", 32'(timeout_err), 32'd0);
    wait_starts(base + 1, 50, "t1_first_start");
    ta = last_start_cyc;
    wait_starts(base + 4, 1500, "t1_second_round");
    tb_t = last_start_cyc;
    check("t1_period_spacing", 32'(tb_t - ta), 32'd1000);
    check("t1_round_done_count", 32'(rd_cnt - rb), 32'd1);
    scan_en = 1'b0;
    wait_idle(100, "t1_idle");

    // Back-to-back rounds with period 0.
    base = start_cnt;
    rb = rd_cnt;
    for (int c = 0; c < 8; c++) push_start(c);
    push_start(0);
    for (int c = 0; c < 8; c++) push_res(c);
    push_res(0);
    ch_mask = 8'hFF;
    period = 16'd0;
    scan_en = 1'b1;
    wait_rounds(rb + 1, 600, "t2_round_done");
    rcyc = last_rd_cyc;
    rd_ch = 3'd5;
    #1;
    check("t2_rd_ch5", 32'(rd_data), 32'h105);
    wait_starts(base + 9, 10, "t2_next_round");
    check("t2_gap", 32'(last_start_cyc - rcyc), 32'd3);
    scan_en = 1'b0;
    wait_idle(100, "t2_idle");

    // scan_en dropped during channel 1 conversion.
    base = start_cnt;
    push_start(0); push_start(1);
    push_res(0); push_res(1);
    ch_mask = 8'h03;
    period = 16'd1000;
    scan_en = 1'b1;
    wait_starts(base + 2, 200, "t4_starts");
    cycles(5);
    scan_en = 1'b0;
    check("t4_busy_inflight", 32'(busy), 32'd1);
    wait_idle(100, "t4_idle");
    cycles(100);
    check("t4_no_more_starts", 32'(start_cnt), 32'(base + 2));
    check("t4_results_drained", 32'(res_q.size()), 32'd0);

    // ch_mask change mid-round takes effect next round.
    base = start_cnt;
    rb = rd_cnt;
    push_start(0); push_start(1); push_start(4); push_start(5);
    push_res(0); push_res(1); push_res(4); push_res(5);
    ch_mask = 8'h03;
    period = 16'd1000;
    scan_en = 1'b1;
    wait_starts(base + 1, 50, "t5_first_start");
    ch_mask = 8'h30;
    wait_starts(base + 4, 1500, "t5_starts");
    check("t5_round_done_count", 32'(rd_cnt - rb), 32'd1);
    scan_en = 1'b0;
    wait_idle(100, "t5_idle");

    // Reset mid-conversion, then a late spi_done.
    base = start_cnt;
    push_start(0);
    ch_mask = 8'h01;
    period = 16'd1000;
    scan_en = 1'b1;
    rd_ch = 3'd5;
    wait_starts(base + 1, 50, "t6_start");
    cycles(10);
    rst_n = 1'b0;
    scan_en = 1'b0;
    #1;
    check_zero_outputs("t6_reset");
    cycles(3);
    rst_n = 1'b1;
    cycles(60);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_res_data", 32'(res_data), 32'd0);
    for (int c = 0; c < 8; c++) begin
      rd_ch = 3'(c);
      #1;
      check("t6_result_cleared", 32'(rd_data), 32'd0);
    end

    check("start_queue_drained", 32'(start_q.size()), 32'd0);
    check("result_queue_drained", 32'(res_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Multi-channel scan scheduler for the 8-channel, 12-bit serial ADC interface block (start/channel/done/data handshake).
- Walks an enabled-channel mask in ascending order, one conversion at a time, and paces scan rounds with a programmable period timer.
- Stores the latest result per channel in a small register file.
- Sits between the system control logic and the SPI ADC block, and is the only master of that block's start/channel inputs.

Parameters:
- NUM_CH, 8, number of ADC channels; must be a power of two.
- CH_W, 3, channel index width (log2 NUM_CH).
- DATA_W, 12, conversion result width.
- PER_W, 16, width of the round period and timer.
- TIMEOUT, 1024, maximum cycles to wait for spi_done before the channel is skipped.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- scan_en  in  1  level; high = scanning enabled.
- ch_mask  in  NUM_CH  enabled channels; bit i = channel i.
- period  in  PER_W  round period in clk cycles.
- spi_start  out  1  one-cycle conversion request to the SPI block.
- spi_channel  out  CH_W  channel to convert.
- spi_done  in  1  conversion complete; sampled high for one or more cycles.
- spi_data  in  DATA_W  conversion result; valid while spi_done is high.
- res_valid  out  1  one-cycle pulse when a result is stored.
- res_ch  out  CH_W  channel of the stored result.
- res_data  out  DATA_W  stored result value.
- rd_ch  in  CH_W  register-file read index.
- rd_data  out  DATA_W  combinational read of result[rd_ch].
- busy  out  1  high in any state other than IDLE.
- round_done  out  1  one-cycle pulse at the end of each scan round.
- timeout_err  out  1  sticky; set on a skipped channel, cleared by reset or by a scan_en rising edge.

Behaviour:
- Reset (async): state IDLE; all outputs 0; result registers 0; timer 0; mask_q 0; channel pointer 0.
- IDLE -> FIND when scan_en=1 and ch_mask!=0.
  - On that edge: mask_q<=ch_mask, ptr<=0, tmr<=0.
  - scan_en=1 with ch_mask=0 stays in IDLE.
- FIND:
  - Selects the lowest set bit c of mask_q with c>=ptr, sets spi_channel<=c, then -> START.
  - If no such bit exists: round_done pulses, then -> WAIT_TMR.
  - Priority encoding completes in one cycle.
- START:
  - spi_start=1 for exactly this one cycle, then -> WAIT_DONE.
  - spi_channel is held constant from FIND until the state leaves WAIT_DONE.
- WAIT_DONE on spi_done=1:
  - result[c]<=spi_data; res_ch<=c; res_data<=spi_data; res_valid pulses on the next cycle.
  - ptr<=c+1, then -> FIND.
  - If c=NUM_CH-1, the pointer wrap is treated as end of round; FIND then reports no bit.
  - Only the first cycle of a multi-cycle spi_done is consumed.
- WAIT_DONE timeout:
  - spi_done absent for TIMEOUT cycles counted from START: set timeout_err, ptr<=c+1, -> FIND.
  - result[c] is not changed on a timeout.
- WAIT_TMR:
  - tmr increments every cycle from the FIND entry that began the round and saturates at all-ones.
  - When tmr>=period-1 and scan_en=1: mask_q<=ch_mask, ptr<=0, tmr<=0, -> FIND.
  - If the new ch_mask is 0, go -> IDLE instead.
  - period=0 or 1, or a round longer than period: the next round starts on the first WAIT_TMR cycle (back-to-back).
- Pacing: with period P and a round shorter than P, successive first-channel spi_start pulses are exactly P cycles apart.
- scan_en dropped:
  - In WAIT_TMR or FIND: -> IDLE on the next edge; no further spi_start is issued.
  - In START or WAIT_DONE: the in-flight conversion completes (or times out) and is stored, then -> IDLE. An SPI transaction is never aborted.
- ch_mask changes mid-round are ignored until the next round boundary.
- period is sampled continuously during WAIT_TMR.
- Simultaneous res_valid and a register-file read of the same channel: rd_data shows the old value that cycle and the new value the following cycle.
- Reset mid-conversion: the FSM returns to IDLE immediately and spi_start stays 0. A later stale spi_done is ignored because it only matters in WAIT_DONE.

Test Plan:
- Bench uses a responder that raises spi_done 40 cycles after spi_start, with spi_data = 12'h100 + channel.
1. ch_mask=8'b1000_0101, period=1000, scan_en=1 -> spi_channel sequence 0,2,7. res_data = 12'h100, 12'h102, 12'h107. round_done once. Next spi_start for channel 0 exactly 1000 cycles after the previous one.
2. period=0, ch_mask=8'hFF -> back-to-back rounds with no idle gap. rd_ch=5 reads 12'h105 after the first round.
3. Responder silent for channel 3, mask 8'h0F, TIMEOUT=1024 -> spi_start for channel 4 absent; channel 3 skipped after 1024 cycles; timeout_err=1; result[3] unchanged (0); round completes with channels 0,1,2.
4. scan_en dropped 5 cycles after spi_start for channel 1 -> channel 1 result stored, res_valid pulses, then IDLE with busy=0 and no further spi_start.
5. ch_mask changed from 8'h03 to 8'h30 mid-round -> current round finishes channels 0,1; next round converts 4,5.
6. rst_n pulsed low during WAIT_DONE, then a late spi_done -> all outputs 0, no res_valid, result registers 0.
